bridge_rx: RTL

BRIDGE_RX -- requirements
Module: bridge_rx

---
 rtl/bridge_rx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bridge_rx.sv
// bridge_rx: ASCII UART command parser issuing 16-bit bus transactions.
// Accepts "R<aaaa><term>" reads and "W<aaaa><dddd><term>" writes.
module bridge_rx #(
   parameter bit ACCEPT_LOWERCASE = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  data_i,
   input  logic        valid_i,
   output logic [15:0] addr_o,
   output logic [15:0] wdata_o,
   output logic [15:0] rdata_o,
   output logic        rw_o,
   output logic        valid_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_TERM
   } state_e;

   localparam logic [7:0] CH_R  = 8'h52;
   localparam logic [7:0] CH_W  = 8'h57;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] addr_sh_q, addr_sh_d;
   logic [15:0] data_sh_q, data_sh_d;
   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        rw_q, rw_d;
   logic        valid_q, valid_d;

   logic        is_hex;
   logic        is_term;
   logic [3:0]  nib;

   // Classify the incoming byte: hex digit value and terminator flag.
   always_comb begin
      is_hex  = 1'b0;
      nib     = 4'h0;
      is_term = (data_i == CH_CR) || (data_i == CH_LF);
      if (data_i >= 8'h30 && data_i <= 8'h39) begin
         is_hex = 1'b1;
         nib    = data_i[3:0];
      end else if (data_i >= 8'h41 && data_i <= 8'h46) begin
         is_hex = 1'b1;
         nib    = data_i[3:0] + 4'd9;
      end else if (ACCEPT_LOWERCASE &&
                   data_i >= 8'h61 && data_i <= 8'h66) begin
         is_hex = 1'b1;
         nib    = data_i[3:0] + 4'd9;
      end
   end

   // Next-state logic: message parsing and transaction issue.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_sh_d = addr_sh_q;
      data_sh_d = data_sh_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rw_d      = rw_q;
      valid_d   = 1'b0;
      if (valid_i) begin
         unique case (state_q)
            S_IDLE: begin
               cnt_d = 3'd0;
               if (data_i == CH_R || data_i == CH_W) begin
                  state_d   = S_ADDR;
                  wr_d      = (data_i == CH_W);
                  addr_sh_d = 16'h0000;
                  data_sh_d = 16'h0000;
               end
            end
            S_ADDR: begin
               if (is_hex) begin
                  addr_sh_d = {addr_sh_q[11:0], nib};
                  if (cnt_q == 3'd3) begin
                     cnt_d   = 3'd0;
                     state_d = wr_q ? S_DATA : S_TERM;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = 3'd0;
               end
            end
            S_DATA: begin
               if (is_hex) begin
                  data_sh_d = {data_sh_q[11:0], nib};
                  if (cnt_q == 3'd3) begin
                     cnt_d   = 3'd0;
                     state_d = S_TERM;
                  end else begin
                     cnt_d = cnt_q + 3'd1;
                  end
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = 3'd0;
               end
            end
            S_TERM: begin
               state_d = S_IDLE;
               cnt_d   = 3'd0;
               if (is_term) begin
                  valid_d = 1'b1;
                  addr_d  = addr_sh_q;
                  wdata_d = wr_q ? data_sh_q : 16'h0000;
                  rw_d    = wr_q;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   // Parser state, digit counter and shift registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 3'd0;
         addr_sh_q <= 16'h0000;
         data_sh_q <= 16'h0000;
         wr_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_sh_q <= addr_sh_d;
         data_sh_q <= data_sh_d;
         wr_q      <= wr_d;
      end
   end

   // Registered bus outputs; held between transactions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         rw_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rw_q    <= rw_d;
         valid_q <= valid_d;
      end
   end

   assign addr_o  = addr_q;
   assign wdata_o = wdata_q;
   assign rdata_o = 16'h0000;
   assign rw_o    = rw_q;
   assign valid_o = valid_q;

endmodule
